// File: rtl/hazard_ctrl_pkg.sv
// Shared core definitions for the pipeline hazard controller and the forwarding unit.
package hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      MEM_WAIT = 2'd2,
      HALTED   = 2'd3
   } hazard_state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_detect.sv
// Load-use compare between the ID sources and the EX destination; also used by forwarding.
module hazard_detect
   import hazard_ctrl_pkg::*;
(
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_use_rs1,
   input  logic       id_use_rs2,
   input  logic [4:0] ex_rd,
   input  logic       ex_is_load,
   output logic       lu
);

   logic rs1_match;
   logic rs2_match;

   // x0 never carries a value, so a load targeting it cannot create a hazard
   always_comb begin
      rs1_match = id_use_rs1 && (id_rs1 == ex_rd);
      rs2_match = id_use_rs2 && (id_rs2 == ex_rd);
      lu        = ex_is_load && (ex_rd != REG_ZERO) && (rs1_match || rs2_match);
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hold/flush controller for the PC and the IF/ID, ID/EX and EX/MEM latches of the 5-stage core.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int LU_STALL_CYCLES = 1,
   parameter int CNT_W           = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_is_load,
   input  logic             ex_branch_taken,
   input  logic             mem_busy,
   input  logic             halt_req,
   input  logic             resume,
   output logic             pc_we,
   output logic             ifid_hold,
   output logic             idex_hold,
   output logic             exmem_hold,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt
);

   hazard_state_t state;
   hazard_state_t state_n;
   hazard_state_t ret_state;
   hazard_state_t ret_state_n;
   hazard_state_t eff_state;
   logic [1:0]    lu_cnt;
   logic [1:0]    lu_cnt_n;
   logic          lu;

   hazard_detect u_detect (
      .id_rs1     (id_rs1),
      .id_rs2     (id_rs2),
      .id_use_rs1 (id_use_rs1),
      .id_use_rs2 (id_use_rs2),
      .ex_rd      (ex_rd),
      .ex_is_load (ex_is_load),
      .lu         (lu)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         ret_state <= RUN;
         lu_cnt    <= 2'd0;
         stall_cnt <= '0;
      end else begin
         state     <= state_n;
         ret_state <= ret_state_n;
         lu_cnt    <= lu_cnt_n;
         if (!pc_we && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
      end
   end

   // MEM_WAIT is transparent once memory is ready: that cycle acts as the interrupted state
   always_comb begin
      eff_state   = (state == MEM_WAIT) ? ret_state : state;
      state_n     = eff_state;
      ret_state_n = ret_state;
      lu_cnt_n    = lu_cnt;
      pc_we       = 1'b1;
      ifid_hold   = 1'b0;
      idex_hold   = 1'b0;
      exmem_hold  = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      halted      = 1'b0;

      if (rst) begin
         pc_we      = 1'b0;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         state_n    = RUN;
      end else if (mem_busy) begin
         pc_we      = 1'b0;
         ifid_hold  = 1'b1;
         idex_hold  = 1'b1;
         exmem_hold = 1'b1;
         halted     = (state == HALTED);
         state_n    = state;
         if ((state != HALTED) && (state != MEM_WAIT)) begin
            state_n     = MEM_WAIT;
            ret_state_n = state;
         end
      end else begin
         case (eff_state)
            RUN: begin
               if (ex_branch_taken) begin
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
                  state_n    = halt_req ? HALTED : RUN;
               end else if (lu) begin
                  pc_we      = 1'b0;
                  ifid_hold  = 1'b1;
                  idex_flush = 1'b1;
                  if (LU_STALL_CYCLES > 1) begin
                     state_n  = LU_STALL;
                     lu_cnt_n = 2'(LU_STALL_CYCLES - 1);
                  end else begin
                     state_n = RUN;
                  end
               end else if (halt_req) begin
                  state_n = HALTED;
               end else begin
                  state_n = RUN;
               end
            end
            LU_STALL: begin
               if (ex_branch_taken) begin
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
                  lu_cnt_n   = 2'd0;
                  state_n    = RUN;
               end else begin
                  pc_we      = 1'b0;
                  ifid_hold  = 1'b1;
                  idex_flush = 1'b1;
                  lu_cnt_n   = lu_cnt - 2'd1;
                  if (lu_cnt <= 2'd1) begin
                     state_n = RUN;
                  end
               end
            end
            HALTED: begin
               pc_we      = 1'b0;
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
               halted     = 1'b1;
               if (resume) begin
                  state_n = RUN;
               end
            end
            default: begin
               state_n = RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (1 and 3 load-use bubbles) share stimulus and are checked against a behavioural model.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic        id_use_rs1, id_use_rs2, ex_is_load, ex_branch_taken;
   logic        mem_busy, halt_req, resume;

   logic        pc_we      [2];
   logic        ifid_hold  [2];
   logic        idex_hold  [2];
   logic        exmem_hold [2];
   logic        ifid_flush [2];
   logic        idex_flush [2];
   logic        halted     [2];
   logic [15:0] stall_cnt_a;
   logic [5:0]  stall_cnt_b;

   int n_pass  = 0;
   int n_total = 0;

   int m_rem  [2] = '{0, 0};
   bit m_halt [2] = '{0, 0};
   int m_cnt  [2] = '{0, 0};

   always #5 clk = ~clk;

   hazard_ctrl #(.LU_STALL_CYCLES(1), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
      .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
      .mem_busy(mem_busy), .halt_req(halt_req), .resume(resume),
      .pc_we(pc_we[0]), .ifid_hold(ifid_hold[0]), .idex_hold(idex_hold[0]),
      .exmem_hold(exmem_hold[0]), .ifid_flush(ifid_flush[0]),
      .idex_flush(idex_flush[0]), .halted(halted[0]), .stall_cnt(stall_cnt_a)
   );

   hazard_ctrl #(.LU_STALL_CYCLES(3), .CNT_W(6)) dut_b (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
      .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
      .mem_busy(mem_busy), .halt_req(halt_req), .resume(resume),
      .pc_we(pc_we[1]), .ifid_hold(ifid_hold[1]), .idex_hold(idex_hold[1]),
      .exmem_hold(exmem_hold[1]), .ifid_flush(ifid_flush[1]),
      .idex_flush(idex_flush[1]), .halted(halted[1]), .stall_cnt(stall_cnt_b)
   );

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_total++;
      if (actual == expected) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic ld, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2,
                                input logic br, input logic mb, input logic hr,
                                input logic res);
      rst = r; ex_is_load = ld; ex_rd = rd;
      id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
      ex_branch_taken = br; mem_busy = mb; halt_req = hr; resume = res;
      #1;
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Model: remaining bubbles, halted flag and a saturating stall count per instance
   initial begin
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            int  n_lu, cmax, act_cnt;
            bit  hz;
            bit  e_pc, e_ifh, e_idh, e_exh, e_iff, e_idf, e_hlt;
            n_lu    = (k == 0) ? 1 : 3;
            cmax    = (k == 0) ? 65535 : 63;
            act_cnt = (k == 0) ? int'(stall_cnt_a) : int'(stall_cnt_b);
            hz = ex_is_load && (ex_rd != 0) &&
                 ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
            e_pc = 1; e_ifh = 0; e_idh = 0; e_exh = 0; e_iff = 0; e_idf = 0; e_hlt = 0;

            if (!rst) checkOutput($sformatf("stall_cnt[%0d]", k), act_cnt, m_cnt[k]);

            if (rst) begin
               e_pc = 0; e_iff = 1; e_idf = 1;
            end else if (mem_busy) begin
               e_pc = 0; e_ifh = 1; e_idh = 1; e_exh = 1; e_hlt = m_halt[k];
            end else if (m_halt[k]) begin
               e_pc = 0; e_iff = 1; e_idf = 1; e_hlt = 1;
            end else if (ex_branch_taken) begin
               e_iff = 1; e_idf = 1;
            end else if (m_rem[k] > 0 || hz) begin
               e_pc = 0; e_ifh = 1; e_idf = 1;
            end

            checkOutput($sformatf("pc_we[%0d]", k),      pc_we[k],      e_pc);
            checkOutput($sformatf("ifid_hold[%0d]", k),  ifid_hold[k],  e_ifh);
            checkOutput($sformatf("idex_hold[%0d]", k),  idex_hold[k],  e_idh);
            checkOutput($sformatf("exmem_hold[%0d]", k), exmem_hold[k], e_exh);
            checkOutput($sformatf("ifid_flush[%0d]", k), ifid_flush[k], e_iff);
            checkOutput($sformatf("idex_flush[%0d]", k), idex_flush[k], e_idf);
            checkOutput($sformatf("halted[%0d]", k),     halted[k],     e_hlt);

            if (rst) begin
               m_rem[k] = 0; m_halt[k] = 0; m_cnt[k] = 0;
            end else begin
               if (!e_pc && m_cnt[k] < cmax) m_cnt[k]++;
               if (mem_busy) begin
               end else if (m_halt[k]) begin
                  if (resume) m_halt[k] = 0;
               end else if (ex_branch_taken) begin
                  if (halt_req && m_rem[k] == 0) m_halt[k] = 1;
                  m_rem[k] = 0;
               end else if (m_rem[k] > 0) begin
                  m_rem[k]--;
               end else if (hz) begin
                  m_rem[k] = n_lu - 1;
               end else if (halt_req) begin
                  m_halt[k] = 1;
               end
            end
         end
      end
   end

   initial begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("reset pc_we", pc_we[0], 0);
      checkOutput("reset ifid_flush", ifid_flush[0], 1);
      checkOutput("reset halted", halted[0], 0);
      step(); step();

      // single load-use bubble on x5 via rs2
      applyStimulus(0, 1, 5, 0, 0, 5, 1, 0, 0, 0, 0);
      checkOutput("lu pc_we", pc_we[0], 0);
      checkOutput("lu ifid_hold", ifid_hold[0], 1);
      checkOutput("lu idex_flush", idex_flush[0], 1);
      step();
      idle();
      checkOutput("lu after pc_we", pc_we[0], 1);
      checkOutput("lu stall_cnt", stall_cnt_a, 1);
      step(); step(); step();

      applyStimulus(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      checkOutput("lu x0 pc_we", pc_we[0], 1);
      step();
      applyStimulus(0, 1, 5, 0, 0, 5, 0, 0, 0, 0, 0);
      checkOutput("lu no-use pc_we", pc_we[0], 1);
      step();

      // three-bubble hazard interrupted by two memory-wait cycles
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      applyStimulus(0, 1, 7, 7, 1, 0, 0, 0, 0, 0, 0);
      checkOutput("n3 first pc_we", pc_we[1], 0);
      step();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      checkOutput("n3 freeze idex_hold", idex_hold[1], 1);
      checkOutput("n3 freeze idex_flush", idex_flush[1], 0);
      step(); step();
      idle();
      checkOutput("n3 resumed stall pc_we", pc_we[1], 0);
      step(); step();
      checkOutput("n3 released pc_we", pc_we[1], 1);
      checkOutput("n3 stall_cnt", stall_cnt_b, 5);
      checkOutput("n1 stall_cnt", stall_cnt_a, 3);
      step();

      // branch wins over a simultaneous load-use
      applyStimulus(0, 1, 9, 9, 1, 0, 0, 1, 0, 0, 0);
      checkOutput("br+lu pc_we", pc_we[1], 1);
      checkOutput("br+lu ifid_flush", ifid_flush[1], 1);
      checkOutput("br+lu idex_flush", idex_flush[1], 1);
      step();
      idle();
      checkOutput("br+lu no stall", pc_we[1], 1);
      step();

      // halt, memory wait while halted, resume
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      checkOutput("halt req halted", halted[0], 0);
      step();
      idle();
      checkOutput("halted flag", halted[0], 1);
      checkOutput("halted pc_we", pc_we[0], 0);
      checkOutput("halted ifid_flush", ifid_flush[0], 1);
      step();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      checkOutput("halted mem exmem_hold", exmem_hold[0], 1);
      checkOutput("halted mem ifid_flush", ifid_flush[0], 0);
      checkOutput("halted mem halted", halted[0], 1);
      step();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      checkOutput("resume cycle halted", halted[0], 1);
      step();
      idle();
      checkOutput("after resume halted", halted[0], 0);
      checkOutput("after resume pc_we", pc_we[0], 1);
      step();

      // branch in the same cycle as halt_req
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
      checkOutput("br+halt pc_we", pc_we[0], 1);
      step();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      checkOutput("br+halt halted", halted[0], 1);
      step();

      // reset during LU_STALL and during HALTED
      applyStimulus(0, 1, 3, 3, 1, 0, 0, 0, 0, 0, 0);
      step();
      idle();
      checkOutput("in lu_stall pc_we", pc_we[1], 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("rst mid-stall ifid_hold", ifid_hold[1], 0);
      checkOutput("rst mid-stall ifid_flush", ifid_flush[1], 1);
      step();
      idle();
      checkOutput("post-rst pc_we", pc_we[1], 1);
      checkOutput("post-rst stall_cnt", stall_cnt_b, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step();
      idle();
      checkOutput("pre-rst halted", halted[1], 1);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("rst mid-halt halted", halted[1], 0);
      step();
      idle();
      checkOutput("post-rst halt pc_we", pc_we[1], 1);
      checkOutput("post-rst halt halted", halted[1], 0);

      // long halt saturates the 6-bit counter
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step();
      idle();
      repeat (70) step();
      checkOutput("sat stall_cnt 6b", stall_cnt_b, 63);
      checkOutput("sat stall_cnt 16b", stall_cnt_a, 70);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step();
      idle();
      step(); step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
